// File: rtl/param_selection_sorter_if.sv
// rtl/param_selection_sorter_if.sv - word-wide single-port memory bus between the sorter and its memory
interface param_selection_sorter_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
);
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_rdy;

    modport master (
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_rdy
    );

    modport slave (
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_rdy
    );
endinterface

// File: rtl/param_selection_sorter.sv
// rtl/param_selection_sorter.sv - in-place selection sort of a memory block, asc/desc, signed/unsigned
module param_selection_sorter #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int SIGNED = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 descending,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      length,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W:0]      swaps,
    param_selection_sorter_if.master mem
);
    typedef enum logic [2:0] {
        S_IDLE, S_RD_I, S_RD_J, S_CMP, S_WR_MIN, S_WR_I, S_NEXT_I, S_DONE
    } state_t;

    localparam logic [ADDR_W:0]   LEN_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_TWO = 2;
    localparam logic [ADDR_W-1:0] IDX_ONE = 1;
    localparam logic [ADDR_W:0]   SW_ONE  = 1;

    state_t              state, state_n;
    logic                desc_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W:0]     len_q;
    logic [ADDR_W-1:0]   i_q, j_q, bidx_q, idx_sel;
    logic [DATA_W-1:0]   key_q, best_q, cur_q;
    logic                rd_q, wr_q, busy_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [ADDR_W:0]     swaps_q;
    logic                pending, retire, is_access, is_rd, issue;
    logic                cur_lt, cur_gt, take, j_last, i_last;
    logic [ADDR_W-1:0]   bidx_nx;

    assign pending = rd_q | wr_q;
    // A ready strobe only counts while a request is outstanding.
    assign retire  = pending & mem.mem_rdy;

    assign cur_lt  = (SIGNED != 0) ? ($signed(cur_q) < $signed(best_q)) : (cur_q < best_q);
    assign cur_gt  = (SIGNED != 0) ? ($signed(cur_q) > $signed(best_q)) : (cur_q > best_q);
    assign take    = desc_q ? cur_gt : cur_lt;
    assign bidx_nx = take ? j_q : bidx_q;
    assign j_last  = ({1'b0, j_q} == (len_q - LEN_ONE));
    assign i_last  = ({1'b0, i_q} == (len_q - LEN_TWO));

    always_comb begin
        is_access = (state == S_RD_I) || (state == S_RD_J) ||
                    (state == S_WR_MIN) || (state == S_WR_I);
        is_rd     = (state == S_RD_I) || (state == S_RD_J);
        issue     = is_access & ~pending;
        case (state)
            S_RD_J:   idx_sel = j_q;
            S_WR_MIN: idx_sel = bidx_q;
            default:  idx_sel = i_q;
        endcase
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:   if (start) state_n = (length <= LEN_ONE) ? S_DONE : S_RD_I;
            S_RD_I:   if (retire) state_n = S_RD_J;
            S_RD_J:   if (retire) state_n = S_CMP;
            S_CMP: begin
                // The swap decision must see the minimum chosen in this very cycle.
                if (j_last) state_n = (bidx_nx != i_q) ? S_WR_MIN : S_NEXT_I;
                else        state_n = S_RD_J;
            end
            S_WR_MIN: if (retire) state_n = S_WR_I;
            S_WR_I:   if (retire) state_n = S_NEXT_I;
            S_NEXT_I: state_n = i_last ? S_DONE : S_RD_I;
            S_DONE:   state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= 1'b0;
            swaps_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            desc_q  <= 1'b0;
            base_q  <= '0;
            len_q   <= '0;
            i_q     <= '0;
            j_q     <= '0;
            bidx_q  <= '0;
            key_q   <= '0;
            best_q  <= '0;
            cur_q   <= '0;
        end else begin
            // Requests are registered so address and data hold still until retired.
            if (issue) begin
                rd_q    <= is_rd;
                wr_q    <= ~is_rd;
                addr_q  <= base_q + idx_sel;
                wdata_q <= (state == S_WR_MIN) ? key_q : best_q;
            end else if (retire) begin
                rd_q <= 1'b0;
                wr_q <= 1'b0;
            end
            case (state)
                S_IDLE: if (start) begin
                    desc_q  <= descending;
                    base_q  <= base_addr;
                    len_q   <= length;
                    swaps_q <= '0;
                    busy_q  <= 1'b1;
                    i_q     <= '0;
                end
                S_RD_I: if (retire) begin
                    key_q  <= mem.mem_rdata;
                    best_q <= mem.mem_rdata;
                    bidx_q <= i_q;
                    j_q    <= i_q + IDX_ONE;
                end
                S_RD_J: if (retire) cur_q <= mem.mem_rdata;
                S_CMP: begin
                    if (take) begin
                        best_q <= cur_q;
                        bidx_q <= j_q;
                    end
                    if (!j_last) j_q <= j_q + IDX_ONE;
                end
                S_WR_I:   if (retire) swaps_q <= swaps_q + SW_ONE;
                S_NEXT_I: if (!i_last) i_q <= i_q + IDX_ONE;
                S_DONE:   busy_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = (state == S_DONE);
    assign swaps         = swaps_q;
    assign mem.mem_read  = rd_q;
    assign mem.mem_write = wr_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_param_selection_sorter.sv
// tb/tb_param_selection_sorter.sv - scoreboard bench for unsigned and signed sorter instances on a shared memory model
module tb_param_selection_sorter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, start_u, start_s, desc;
    logic [7:0] base;
    logic [8:0] length;
    logic       busy_u, busy_s, done_u, done_s;
    logic [8:0] swaps_u, swaps_s;

    param_selection_sorter_if #(.DATA_W(16), .ADDR_W(8)) ifu ();
    param_selection_sorter_if #(.DATA_W(16), .ADDR_W(8)) ifs ();

    param_selection_sorter #(.DATA_W(16), .ADDR_W(8), .SIGNED(0)) dut_u (
        .clk(clk), .rst(rst), .start(start_u), .descending(desc), .base_addr(base),
        .length(length), .busy(busy_u), .done(done_u), .swaps(swaps_u), .mem(ifu.master));
    param_selection_sorter #(.DATA_W(16), .ADDR_W(8), .SIGNED(1)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .descending(desc), .base_addr(base),
        .length(length), .busy(busy_s), .done(done_s), .swaps(swaps_s), .mem(ifs.master));

    typedef struct packed {
        bit               sel;
        logic [7:0]       base;
        logic [8:0]       n;
        logic [0:7][15:0] vals;
        logic [8:0]       swaps;
        logic [15:0]      reads;
        logic [15:0]      writes;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0, done_cnt = 0, rd_cnt = 0, wr_cnt = 0;
    bit   sel = 1'b0, rand_dly = 1'b0;
    logic [15:0] mem [0:255];
    logic        rdy = 1'b0;
    logic [15:0] rdata = 16'h0;

    logic        req_rd, req_wr;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    assign req_rd    = sel ? ifs.mem_read  : ifu.mem_read;
    assign req_wr    = sel ? ifs.mem_write : ifu.mem_write;
    assign req_addr  = sel ? ifs.mem_addr  : ifu.mem_addr;
    assign req_wdata = sel ? ifs.mem_wdata : ifu.mem_wdata;
    assign ifu.mem_rdy   = rdy & ~sel;
    assign ifs.mem_rdy   = rdy & sel;
    assign ifu.mem_rdata = rdata;
    assign ifs.mem_rdata = rdata;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    int          m_cnt = 0, m_dly = 0;
    bit          m_trk = 1'b0, m_rd = 1'b0;
    logic [7:0]  m_addr;
    logic [15:0] m_wdata;

    always @(posedge clk) begin
        rdy <= 1'b0;
        if (rst) begin
            m_cnt = 0;
            m_trk = 1'b0;
        end else if (req_rd || req_wr) begin
            if (req_rd && req_wr) chk("rd_wr_exclusive", 1, 0);
            if (!m_trk) begin
                m_trk = 1'b1; m_addr = req_addr; m_wdata = req_wdata; m_rd = req_rd;
            end else begin
                chk("addr_stable", req_addr, m_addr);
                if (!m_rd) chk("wdata_stable", req_wdata, m_wdata);
            end
            if (!rdy) begin
                if (m_cnt >= m_dly) begin
                    rdy <= 1'b1;
                    m_cnt = 0;
                    m_dly = rand_dly ? int'($urandom_range(0, 7)) : 0;
                    if (m_rd) begin
                        rdata <= mem[req_addr];
                        rd_cnt++;
                    end else begin
                        mem[req_addr] = req_wdata;
                        wr_cnt++;
                    end
                end else begin
                    m_cnt++;
                end
            end
        end else begin
            m_trk = 1'b0;
            m_cnt = 0;
        end
    end

    always @(negedge clk) begin : monitor
        exp_t e;
        if (done_u || done_s) begin
            done_cnt++;
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = sb.pop_front();
                chk("done_source", {31'b0, done_s}, {31'b0, e.sel});
                chk("swaps", e.sel ? swaps_s : swaps_u, e.swaps);
                for (int k = 0; k < int'(e.n); k++)
                    chk($sformatf("word[%0d]", k), mem[8'(e.base + k)], e.vals[k]);
                chk("guard_lo", mem[8'(e.base - 1)], 16'hDEAD);
                chk("guard_hi", mem[8'(e.base + e.n)], 16'hDEAD);
                chk("reads", rd_cnt, e.reads);
                chk("writes", wr_cnt, e.writes);
            end
        end
    end

    task automatic run_sort(input bit s, input bit d, input logic [7:0] b, input int n,
                            input logic [0:7][15:0] din, input logic [0:7][15:0] dexp,
                            input int sw, input bit mid);
        exp_t e;
        int   prev, cyc;
        @(negedge clk);
        for (int a = 0; a < 256; a++) mem[a] = 16'hDEAD;
        for (int k = 0; k < n; k++) mem[8'(b + k)] = din[k];
        rd_cnt = 0; wr_cnt = 0; sel = s;
        e.sel = s; e.base = b; e.n = 9'(n); e.vals = dexp; e.swaps = 9'(sw);
        e.reads  = (n >= 2) ? 16'(n * (n + 1) / 2 - 1) : 16'd0;
        e.writes = 16'(2 * sw);
        sb.push_back(e);
        prev = done_cnt;
        desc = d; base = b; length = 9'(n);
        if (s) start_s = 1'b1; else start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0; start_s = 1'b0;
        chk("busy_after_start", s ? busy_s : busy_u, 1);
        cyc = 0;
        while (done_cnt == prev && cyc < 4000) begin
            @(posedge clk); #1;
            cyc++;
            if (mid && cyc == 12) begin
                length = 9'd0;
                if (s) start_s = 1'b1; else start_u = 1'b1;
            end else if (mid && cyc == 13) begin
                start_u = 1'b0; start_s = 1'b0; length = 9'(n);
            end
        end
        start_u = 1'b0; start_s = 1'b0; length = 9'(n);
        if (done_cnt == prev) begin
            chk("done_timeout", 1, 0);
            if (sb.size() > 0) void'(sb.pop_back());
        end
        @(negedge clk);
        chk("busy_after_done", s ? busy_s : busy_u, 0);
        chk("done_one_pulse", s ? done_s : done_u, 0);
        chk("done_count", done_cnt - prev, 1);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int cyc;
        rst = 1'b1; start_u = 1'b0; start_s = 1'b0; desc = 1'b0; base = 8'h0; length = 9'h0;
        for (int a = 0; a < 256; a++) mem[a] = 16'hDEAD;
        repeat (3) @(negedge clk);
        chk("rst_busy", {busy_u, busy_s}, 0);
        chk("rst_done", {done_u, done_s}, 0);
        chk("rst_req", {ifu.mem_read, ifu.mem_write, ifs.mem_read, ifs.mem_write}, 0);
        chk("rst_addr", {ifu.mem_addr, ifs.mem_addr}, 0);
        chk("rst_wdata", {ifu.mem_wdata, ifs.mem_wdata}, 0);
        chk("rst_swaps", {swaps_u, swaps_s}, 0);
        rst = 1'b0;

        run_sort(0, 0, 8'h10, 8, {16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4},
                 {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7, 16'd8, 16'd9}, 6, 0);
        run_sort(0, 1, 8'h30, 8, {16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4},
                 {16'd9, 16'd8, 16'd7, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 6, 0);
        run_sort(0, 0, 8'h40, 4, {16'd1, 16'd2, 16'd3, 16'd4, 64'd0},
                 {16'd1, 16'd2, 16'd3, 16'd4, 64'd0}, 0, 0);
        run_sort(1, 0, 8'h50, 4, {16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 64'd0},
                 {16'h8000, 16'hFFFF, 16'h0001, 16'h7FFF, 64'd0}, 1, 0);
        run_sort(0, 0, 8'h50, 4, {16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 64'd0},
                 {16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF, 64'd0}, 1, 0);
        run_sort(0, 0, 8'hFE, 4, {16'd4, 16'd3, 16'd2, 16'd1, 64'd0},
                 {16'd1, 16'd2, 16'd3, 16'd4, 64'd0}, 2, 0);
        run_sort(0, 0, 8'h20, 0, {16'd7, 16'd0, 16'd0, 16'd0, 64'd0},
                 {16'd7, 16'd0, 16'd0, 16'd0, 64'd0}, 0, 0);
        run_sort(1, 1, 8'h20, 1, {16'd7, 16'd0, 16'd0, 16'd0, 64'd0},
                 {16'd7, 16'd0, 16'd0, 16'd0, 64'd0}, 0, 0);

        rand_dly = 1'b1;
        run_sort(0, 0, 8'h60, 4, {16'd2, 16'd2, 16'd1, 16'd2, 64'd0},
                 {16'd1, 16'd2, 16'd2, 16'd2, 64'd0}, 1, 1);
        run_sort(1, 1, 8'h70, 8, {16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4},
                 {16'd9, 16'd8, 16'd7, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, 6, 1);
        rand_dly = 1'b0;

        // Abort: reset lands while the first RD_J access (address base+1) is outstanding.
        @(negedge clk);
        for (int a = 0; a < 256; a++) mem[a] = 16'hDEAD;
        mem[8'h10] = 16'd5; mem[8'h11] = 16'd3; mem[8'h12] = 16'd8; mem[8'h13] = 16'd1;
        sel = 1'b0; desc = 1'b0; base = 8'h10; length = 9'd8;
        start_u = 1'b1;
        @(negedge clk);
        start_u = 1'b0;
        cyc = 0;
        while (!(ifu.mem_read && ifu.mem_addr == 8'h11) && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("abort_reached_rd_j", (cyc < 200) ? 1 : 0, 1);
        cyc = done_cnt;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_mem_read", ifu.mem_read, 0);
        chk("abort_busy", busy_u, 0);
        chk("abort_done", done_u, 0);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - cyc, 0);

        run_sort(0, 0, 8'h10, 8, {16'd5, 16'd3, 16'd8, 16'd1, 16'd9, 16'd2, 16'd7, 16'd4},
                 {16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd7, 16'd8, 16'd9}, 6, 0);

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
